// File: rtl/riscv_v_mem_lsu.sv
// ============================================================================
// Module : riscv_v_mem_lsu
// Desc   : Vector MEM stage: registers ALU results, splits vector loads/stores
//          into BUS_W beats on a valid/ready memory port, stalls until done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_v_mem_lsu #(
    parameter int VLEN   = 128,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32,
    parameter int RS_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_exe,
    input  logic                is_load_exe,
    input  logic                is_store_exe,
    input  logic [ADDR_W-1:0]   base_addr_exe,
    input  logic [VLEN-1:0]     alu_result_exe,
    input  logic [VLEN/8-1:0]   byte_en_exe,
    input  logic [RS_W-1:0]     rf_wr_addr_exe,
    output logic                stall_mem,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [BUS_W-1:0]    mem_req_wdata,
    output logic [BUS_W/8-1:0]  mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [BUS_W-1:0]    mem_rsp_rdata,
    output logic [VLEN/8-1:0]   rf_wr_en_mem,
    output logic [RS_W-1:0]     rf_wr_addr_mem,
    output logic [VLEN-1:0]     rf_wr_data_mem
);

    localparam int c_NBEATS = VLEN / BUS_W;
    localparam int c_BB     = BUS_W / 8;
    localparam int c_OFF_W  = $clog2(c_BB);
    localparam int c_BEAT_W = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [ADDR_W-1:0]      r_base;
    logic [VLEN-1:0]        r_data;
    logic [VLEN/8-1:0]      r_byte_en;
    logic [RS_W-1:0]        r_rd;
    logic                   r_is_load;
    logic                   r_req_we;
    logic [ADDR_W-1:0]      r_req_addr;
    logic [BUS_W-1:0]       r_req_wdata;
    logic [c_BB-1:0]        r_req_be;
    logic [VLEN/8-1:0]      r_wr_en;
    logic [RS_W-1:0]        r_wr_addr;
    logic [VLEN-1:0]        r_wr_data;

    logic [c_NBEATS-1:0]    w_act_exe;
    logic [c_NBEATS-1:0]    w_act_cap;
    logic [c_BEAT_W:0]      w_first;
    logic [c_BEAT_W:0]      w_next;
    logic [ADDR_W-1:0]      w_base_exe;
    logic                   w_is_mem;
    logic [c_BEAT_W-1:0]    w_l_idx;
    logic [ADDR_W-1:0]      w_l_base;
    logic [VLEN-1:0]        w_l_src;
    logic [VLEN/8-1:0]      w_l_mask;
    logic [ADDR_W-1:0]      w_l_addr;
    logic [BUS_W-1:0]       w_l_wdata;
    logic [c_BB-1:0]        w_l_be;
    logic [VLEN-1:0]        w_merged;

    genvar gi;
    generate
        for (gi = 0; gi < c_NBEATS; gi++) begin : g_beat_act
            assign w_act_exe[gi] = |byte_en_exe[gi*c_BB +: c_BB];
            assign w_act_cap[gi] = |r_byte_en[gi*c_BB +: c_BB];
        end
    endgenerate

    // Lowest active beat at or above start; MSB flags that one was found.
    function automatic logic [c_BEAT_W:0] f_find_beat(input logic [c_NBEATS-1:0] act,
                                                      input int start);
        logic [c_BEAT_W:0] res;
        res = '0;
        for (int k = c_NBEATS - 1; k >= 0; k--) begin
            if (act[k] && (k >= start)) begin
                res = {1'b1, c_BEAT_W'(k)};
            end
        end
        return res;
    endfunction

    assign w_base_exe = base_addr_exe & ~ADDR_W'(c_BB - 1);
    assign w_is_mem   = is_load_exe | is_store_exe;
    assign w_first    = f_find_beat(w_act_exe, 0);
    assign w_next     = f_find_beat(w_act_cap, int'(r_beat) + 1);

    // The beat about to be launched comes from the captured op while in WAIT,
    // otherwise straight from the execute stage on acceptance.
    always_comb begin
        if (r_state == S_WAIT) begin
            w_l_idx  = w_next[c_BEAT_W-1:0];
            w_l_base = r_base;
            w_l_src  = r_data;
            w_l_mask = r_byte_en;
        end else begin
            w_l_idx  = w_first[c_BEAT_W-1:0];
            w_l_base = w_base_exe;
            w_l_src  = alu_result_exe;
            w_l_mask = byte_en_exe;
        end
        w_l_addr  = w_l_base + (ADDR_W'(w_l_idx) << c_OFF_W);
        w_l_wdata = w_l_src[int'(w_l_idx)*BUS_W +: BUS_W];
        w_l_be    = w_l_mask[int'(w_l_idx)*c_BB +: c_BB];
    end

    always_comb begin
        w_merged = r_data;
        for (int b = 0; b < c_BB; b++) begin
            if (r_req_be[b]) begin
                w_merged[int'(r_beat)*BUS_W + b*8 +: 8] = mem_rsp_rdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_base      <= '0;
            r_data      <= '0;
            r_byte_en   <= '0;
            r_rd        <= '0;
            r_is_load   <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (valid_exe && w_is_mem) begin
                        r_base    <= w_base_exe;
                        r_data    <= alu_result_exe;
                        r_byte_en <= byte_en_exe;
                        r_rd      <= rf_wr_addr_exe;
                        r_is_load <= is_load_exe;
                        r_req_we  <= ~is_load_exe;
                        if (w_first[c_BEAT_W]) begin
                            r_state     <= S_REQ;
                            r_beat      <= w_first[c_BEAT_W-1:0];
                            r_req_addr  <= w_l_addr;
                            r_req_wdata <= w_l_wdata;
                            r_req_be    <= w_l_be;
                        end else begin
                            r_state <= S_DONE;
                            if (is_load_exe) begin
                                r_wr_en   <= byte_en_exe;
                                r_wr_addr <= rf_wr_addr_exe;
                                r_wr_data <= alu_result_exe;
                            end
                        end
                    end else if (valid_exe) begin
                        r_wr_en   <= byte_en_exe;
                        r_wr_addr <= rf_wr_addr_exe;
                        r_wr_data <= alu_result_exe;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_is_load) begin
                            r_data <= w_merged;
                        end
                        if (w_next[c_BEAT_W]) begin
                            r_state     <= S_REQ;
                            r_beat      <= w_next[c_BEAT_W-1:0];
                            r_req_addr  <= w_l_addr;
                            r_req_wdata <= w_l_wdata;
                            r_req_be    <= w_l_be;
                        end else begin
                            r_state <= S_DONE;
                            if (r_is_load) begin
                                r_wr_en   <= r_byte_en;
                                r_wr_addr <= r_rd;
                                r_wr_data <= w_merged;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_mem      = (r_state == S_REQ) || (r_state == S_WAIT);
    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_req_we     = r_req_we;
    assign mem_req_addr   = r_req_addr;
    assign mem_req_wdata  = r_req_wdata;
    assign mem_req_be     = r_req_be;
    assign rf_wr_en_mem   = r_wr_en;
    assign rf_wr_addr_mem = r_wr_addr;
    assign rf_wr_data_mem = r_wr_data;

endmodule

`default_nettype wire
